mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameters: none; data path fixed at 64 bits, byte-addressed memory port.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  core presents an access.
REQ-005 req_ready  out  1  block accepts the access this cycle.
REQ-006 req_store  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-008 req_unsigned  in  1  zero-extend load data when 1.
REQ-009 req_addr  in  64  byte address, any alignment.
REQ-010 req_wdata  in  64  store data, right-justified.
REQ-011 rsp_valid  out  1  completion available.
REQ-012 rsp_ready  in  1  core consumes the completion.
REQ-013 rsp_data  out  64  extended load data; 0 for stores and faults.
REQ-014 rsp_exc  out  1  access fault on any beat.
REQ-015 mem_addr  out  64  8-byte-aligned address to the memory data port.
REQ-016 mem_data  out  64  lane-aligned store data.
REQ-017 mem_wren  out  1  write enable, sampled by memory at posedge clk.
REQ-018 mem_mask  out  8  byte-lane enables; bit i = byte mem_addr+i.
REQ-019 mem_resp  in  64  combinational read data for mem_addr.
REQ-020 mem_exc  in  1  combinational fault flag for mem_addr.

Function
REQ-021 The FSM SHALL have the states IDLE, BEAT0, BEAT1 and RESP; req_ready = 1 only in IDLE.
REQ-022 On req_valid&&req_ready the block SHALL latch the request and enter BEAT0 in the next cycle.
REQ-023 Derived values: n = 1<<size; off = addr[2:0]; split = (off+n > 8).
REQ-024 In BEAT0, mem_addr = {addr[63:3],3'b0}, mem_mask = (((1<<n)-1)<<off)[7:0], and mem_data = (wdata<<8*off)[63:0].
REQ-025 In BEAT1, mem_addr = BEAT0 address + 8, modulo 2^64 (0xFFFF_FFFF_FFFF_FFF8 wraps to 0), mem_mask = ((1<<n)-1)>>(8-off), and mem_data = wdata>>8*(8-off).
REQ-026 mem_wren = req_store && !mem_exc during BEAT0/BEAT1; a faulting beat SHALL never write.
REQ-027 In IDLE and RESP, mem_addr, mem_data, mem_wren and mem_mask SHALL all be 0.
REQ-028 BEAT0 transitions: to RESP if mem_exc or !split; otherwise to BEAT1. BEAT1 always transitions to RESP.
REQ-029 Loads: bytes mem_resp>>8*off are captured in BEAT0; in BEAT1, mem_resp bytes [0..off+n-9] are placed at byte positions 8-off and up.
REQ-030 Assembled load data SHALL be truncated to n bytes, then sign-extended from bit 8n-1 unless req_unsigned or size = 3.
REQ-031 A fault in any beat SHALL set rsp_exc = 1 and force rsp_data = 0.
REQ-032 In RESP, rsp_valid = 1, with rsp_data and rsp_exc held stable until rsp_ready; on rsp_ready the block returns to IDLE.
REQ-033 No new request SHALL be accepted in the cycle that rsp_ready is seen; the next acceptance is the following cycle.
REQ-034 Latency from acceptance cycle T: rsp_valid rises at T+2 (unsplit or BEAT0 fault) or at T+3 (split).
REQ-035 Memory traffic: exactly one beat per cycle; no beat is issued while in RESP.

Reset
REQ-036 While reset is high: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_exc = 0, and all mem_* outputs = 0.
REQ-037 Reset asserted mid-access (BEAT0, BEAT1 or RESP) SHALL discard the access; mem_wren drops immediately and the pending completion is lost.

Verification
REQ-038 Load word signed @0x100, memory bytes 0x100..0x103 = 78 56 34 92 -> mem_mask 0x0F; rsp_data 0xFFFF_FFFF_9234_5678 at T+2; rsp_exc 0.
REQ-039 Store half 0xBEEF @0x103 -> single beat: mem_addr 0x100, mem_mask 0x18, mem_data 0x0000_00BE_EF00_0000, mem_wren 1; rsp_valid at T+2.
REQ-040 Store double 0x1122334455667788 @0x1FD -> BEAT0: 0x1F8 / mask 0xE0 / data 0x6677_8800_0000_0000; BEAT1: 0x200 / mask 0x1F / data 0x0000_0011_2233_4455; rsp at T+3.
REQ-041 Split unsigned word load @0xFFFFE after bytes are preloaded -> reassembled correctly across 0xFFFF8/0x100000; BEAT1 mem_exc -> rsp_exc 1, rsp_data 0.
REQ-042 Store @0x100000 (mem_exc = 1) -> mem_wren held 0, no BEAT1, rsp_exc 1; a subsequent load @0x0 returns the memory contents unchanged.
REQ-043 Hold rsp_ready = 0 for 3 cycles -> rsp_valid/rsp_data stable and req_ready 0; then assert reset during BEAT1 of a split store -> mem_wren 0 the same cycle, IDLE afterward.

Source files
------------

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: core request/response handshake and memory data port.
// slave is the LSU view, master is the core/memory view.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_exc;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic        mem_wren;
    logic [7:0]  mem_mask;
    logic [63:0] mem_resp;
    logic        mem_exc;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned,
        input  req_addr, req_wdata, rsp_ready, mem_resp, mem_exc,
        output req_ready, rsp_valid, rsp_data, rsp_exc,
        output mem_addr, mem_data, mem_wren, mem_mask
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned,
        output req_addr, req_wdata, rsp_ready, mem_resp, mem_exc,
        input  req_ready, rsp_valid, rsp_data, rsp_exc,
        input  mem_addr, mem_data, mem_wren, mem_mask
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: 64-bit load/store unit for unaligned accesses.
// Misaligned accesses crossing an 8-byte line take a second beat.
module mem_lsu (
    input  logic     clk,
    input  logic     reset,
    mem_lsu_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] ld_q, ld_d;
    logic [63:0] rsp_q, rsp_d;
    logic        exc_q, exc_d;

    logic [2:0]   off;
    logic [3:0]   nbytes;
    logic         split;
    logic [15:0]  mask_w;
    logic [127:0] data_w;
    logic [63:0]  base;
    logic [63:0]  asm0;
    logic [63:0]  asm1;

    function automatic logic [63:0] extend(
        input logic [63:0] d,
        input logic [1:0]  sz,
        input logic        u
    );
        logic [63:0] r;
        case (sz)
            2'd0:    r = u ? {56'd0, d[7:0]}
                           : {{56{d[7]}}, d[7:0]};
            2'd1:    r = u ? {48'd0, d[15:0]}
                           : {{48{d[15]}}, d[15:0]};
            2'd2:    r = u ? {32'd0, d[31:0]}
                           : {{32{d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Lane placement of the latched access across two 8-byte lines
    always_comb begin
        off    = addr_q[2:0];
        nbytes = 4'd1 << size_q;
        split  = ({1'b0, off} + nbytes) > 4'd8;
        mask_w = ((16'd1 << nbytes) - 16'd1) << off;
        data_w = {64'd0, wdata_q} << {off, 3'b000};
        base   = {addr_q[63:3], 3'b000};
        asm0   = bus.mem_resp >> {off, 3'b000};
        asm1   = ld_q
               | (bus.mem_resp << {(4'd8 - {1'b0, off}), 3'b000});
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
        end else if (state_q == IDLE && bus.req_valid) begin
            store_q <= bus.req_store;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Load assembly and completion registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_q  <= 64'd0;
            rsp_q <= 64'd0;
            exc_q <= 1'b0;
        end else begin
            ld_q  <= ld_d;
            rsp_q <= rsp_d;
            exc_q <= exc_d;
        end
    end

    // Next state, memory beats and response outputs
    always_comb begin
        state_d       = state_q;
        ld_d          = ld_q;
        rsp_d         = rsp_q;
        exc_d         = exc_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = 64'd0;
        bus.rsp_exc   = 1'b0;
        bus.mem_addr  = 64'd0;
        bus.mem_data  = 64'd0;
        bus.mem_wren  = 1'b0;
        bus.mem_mask  = 8'd0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                bus.mem_addr = base;
                bus.mem_mask = mask_w[7:0];
                bus.mem_data = data_w[63:0];
                bus.mem_wren = store_q && !bus.mem_exc;
                ld_d         = asm0;
                exc_d        = bus.mem_exc;
                if (bus.mem_exc) begin
                    rsp_d   = 64'd0;
                    state_d = RESP;
                end else if (!split) begin
                    rsp_d   = store_q ? 64'd0
                                      : extend(asm0, size_q, uns_q);
                    state_d = RESP;
                end else begin
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                bus.mem_addr = base + 64'd8;
                bus.mem_mask = mask_w[15:8];
                bus.mem_data = data_w[127:64];
                bus.mem_wren = store_q && !bus.mem_exc;
                exc_d        = bus.mem_exc;
                if (bus.mem_exc || store_q) begin
                    rsp_d = 64'd0;
                end else begin
                    rsp_d = extend(asm1, size_q, uns_q);
                end
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = rsp_q;
                bus.rsp_exc   = exc_q;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end
endmodule
